// File: rtl/bus_cycle_ctrl_if.sv
// Bus-cycle signal bundle between the 68000 side (master) and the cycle controller (slave).
interface bus_cycle_ctrl_if;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        w_n;
    logic [2:0]  fc;
    logic [23:0] logaddr;
    logic        bg_n;
    logic        csrom_n;
    logic        csram1_n;
    logic        csram2_n;
    logic        re_n;
    logic        we_n;
    logic        dtack_n;
    logic        berr_n;
    logic        avec_n;
    logic        busy;

    modport master (
        output as_n, uds_n, lds_n, w_n, fc, logaddr, bg_n,
        input  csrom_n, csram1_n, csram2_n, re_n, we_n, dtack_n, berr_n, avec_n, busy
    );

    modport slave (
        input  as_n, uds_n, lds_n, w_n, fc, logaddr, bg_n,
        output csrom_n, csram1_n, csram2_n, re_n, we_n, dtack_n, berr_n, avec_n, busy
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle sequencer: AS synchroniser, address decode, chip selects,
// read/write strobes, per-region wait states, autovector IACK and BERR timeout.
// Every output is a register; the next-state logic computes their next values.
module bus_cycle_ctrl #(
    parameter int          ROM_WAIT = 4,
    parameter int          RAM_WAIT = 2,
    parameter logic [7:0]  TIMEOUT  = 8'd200
) (
    input  logic             sysclk,
    input  logic             sysrst,
    bus_cycle_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_TMO,
        ST_ACK,
        ST_FAULT
    } state_t;

    typedef enum logic [2:0] {
        RG_IACK,
        RG_ROM,
        RG_RAM1,
        RG_RAM2,
        RG_UNMAP
    } region_t;

    localparam logic [7:0] ROM_WAIT_C = 8'(ROM_WAIT);
    localparam logic [7:0] RAM_WAIT_C = 8'(RAM_WAIT);
    localparam logic [7:0] TMO_LOAD_C = TIMEOUT - 8'd1;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_as_s1, r_as_s;
    logic        r_csrom_n, r_csram1_n, r_csram2_n, r_re_n, r_we_n;
    logic        r_dtack_n, r_berr_n, r_avec_n, r_busy;
    logic        w_csrom_n, w_csram1_n, w_csram2_n, w_re_n, w_we_n;
    logic        w_dtack_n, w_berr_n, w_avec_n;
    logic        w_we_ok;
    region_t     w_region;

    // Only the top nibble of the address selects a region.
    logic        w_unused;
    assign w_unused = &{1'b0, bus.logaddr[19:0]};

    // Two-flop synchroniser for the asynchronous address strobe.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_as_s1 <= 1'b1;
            r_as_s  <= 1'b1;
        end else begin
            r_as_s1 <= bus.as_n;
            r_as_s  <= r_as_s1;
        end
    end

    // Region decode; interrupt acknowledge takes priority over any address.
    always_comb begin
        w_region = RG_UNMAP;
        if (bus.fc == 3'b111) begin
            w_region = RG_IACK;
        end else begin
            case (bus.logaddr[23:20])
                4'h0:    w_region = RG_ROM;
                4'h1:    w_region = RG_RAM1;
                4'h2:    w_region = RG_RAM2;
                default: w_region = RG_UNMAP;
            endcase
        end
    end

    // A write strobe is only issued when at least one data strobe is active.
    assign w_we_ok = ~(bus.uds_n & bus.lds_n);

    // State and registered-output update.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_csrom_n  <= 1'b1;
            r_csram1_n <= 1'b1;
            r_csram2_n <= 1'b1;
            r_re_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_dtack_n  <= 1'b1;
            r_berr_n   <= 1'b1;
            r_avec_n   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_csrom_n  <= w_csrom_n;
            r_csram1_n <= w_csram1_n;
            r_csram2_n <= w_csram2_n;
            r_re_n     <= w_re_n;
            r_we_n     <= w_we_n;
            r_dtack_n  <= w_dtack_n;
            r_berr_n   <= w_berr_n;
            r_avec_n   <= w_avec_n;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next state, wait counter and next output values; outputs hold by default.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_csrom_n   = r_csrom_n;
        w_csram1_n  = r_csram1_n;
        w_csram2_n  = r_csram2_n;
        w_re_n      = r_re_n;
        w_we_n      = r_we_n;
        w_dtack_n   = r_dtack_n;
        w_berr_n    = r_berr_n;
        w_avec_n    = r_avec_n;

        case (r_state)
            ST_IDLE: begin
                if (!r_as_s && bus.bg_n) begin
                    case (w_region)
                        RG_IACK: begin
                            w_state_nxt = ST_ACK;
                            w_avec_n    = 1'b0;
                        end
                        RG_UNMAP: begin
                            w_state_nxt = ST_TMO;
                            w_cnt_nxt   = TMO_LOAD_C;
                        end
                        default: begin
                            w_state_nxt = ST_ACCESS;
                            w_cnt_nxt   = (w_region == RG_ROM) ? ROM_WAIT_C : RAM_WAIT_C;
                            w_csrom_n   = (w_region != RG_ROM);
                            w_csram1_n  = (w_region != RG_RAM1);
                            w_csram2_n  = (w_region != RG_RAM2);
                            w_re_n      = ~bus.w_n;
                            w_we_n      = ~(~bus.w_n & w_we_ok);
                        end
                    endcase
                end
            end
            ST_ACCESS, ST_TMO: begin
                if (r_as_s) begin
                    // CPU abandoned the cycle: release everything without an acknowledge.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_csrom_n   = 1'b1;
                    w_csram1_n  = 1'b1;
                    w_csram2_n  = 1'b1;
                    w_re_n      = 1'b1;
                    w_we_n      = 1'b1;
                end else if (r_cnt == 8'd0) begin
                    if (r_state == ST_ACCESS) begin
                        w_state_nxt = ST_ACK;
                        w_dtack_n   = 1'b0;
                    end else begin
                        w_state_nxt = ST_FAULT;
                        w_berr_n    = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_ACK, ST_FAULT: begin
                if (r_as_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_csrom_n   = 1'b1;
                    w_csram1_n  = 1'b1;
                    w_csram2_n  = 1'b1;
                    w_re_n      = 1'b1;
                    w_we_n      = 1'b1;
                    w_dtack_n   = 1'b1;
                    w_berr_n    = 1'b1;
                    w_avec_n    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.csrom_n  = r_csrom_n;
    assign bus.csram1_n = r_csram1_n;
    assign bus.csram2_n = r_csram2_n;
    assign bus.re_n     = r_re_n;
    assign bus.we_n     = r_we_n;
    assign bus.dtack_n  = r_dtack_n;
    assign bus.berr_n   = r_berr_n;
    assign bus.avec_n   = r_avec_n;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl. Observed vector is
// {busy, csrom_n, csram1_n, csram2_n, re_n, we_n, dtack_n, berr_n, avec_n}.
module tb_bus_cycle_ctrl;

    logic sysclk;
    logic sysrst;
    int   n_checks;
    int   n_errors;

    localparam logic [8:0] V_IDLE      = 9'h0FF;
    localparam logic [8:0] V_ROM_MID   = 9'h16F;
    localparam logic [8:0] V_ROM_ACK   = 9'h16B;
    localparam logic [8:0] V_RAM1R_MID = 9'h1AF;
    localparam logic [8:0] V_RAM1R_ACK = 9'h1AB;
    localparam logic [8:0] V_RAM1N_MID = 9'h1BF;
    localparam logic [8:0] V_RAM1N_ACK = 9'h1BB;
    localparam logic [8:0] V_RAM2W_MID = 9'h1D7;
    localparam logic [8:0] V_RAM2W_ACK = 9'h1D3;
    localparam logic [8:0] V_UNM_MID   = 9'h1FF;
    localparam logic [8:0] V_UNM_BERR  = 9'h1FD;
    localparam logic [8:0] V_IACK      = 9'h1FE;

    bus_cycle_ctrl_if bif ();

    bus_cycle_ctrl #(
        .ROM_WAIT (4),
        .RAM_WAIT (2),
        .TIMEOUT  (8'd200)
    ) dut (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .bus    (bif)
    );

    initial sysclk = 1'b0;
    always #10 sysclk = ~sysclk;

    function automatic logic [8:0] obs();
        return {bif.busy, bif.csrom_n, bif.csram1_n, bif.csram2_n, bif.re_n,
                bif.we_n, bif.dtack_n, bif.berr_n, bif.avec_n};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_bus(input logic [23:0] a, input logic [2:0] f, input logic w,
                           input logic u, input logic l);
        bif.logaddr = a;
        bif.fc      = f;
        bif.w_n     = w;
        bif.uds_n   = u;
        bif.lds_n   = l;
    endtask

    // Raise AS and expect everything released within three edges.
    task automatic end_cycle(input string tag);
        bif.as_n = 1'b1;
        tick();
        tick();
        tick();
        chk({tag, "_release"}, 32'(obs()), 32'(V_IDLE));
    endtask

    // Full cycle: AS low at edge N, strobes at N+2, acknowledge at N+2+lat.
    task automatic do_cycle(input string tag, input int lat,
                            input logic [8:0] mid, input logic [8:0] fin);
        bif.as_n = 1'b0;
        tick();
        tick();
        chk({tag, "_n1"}, 32'(obs()), 32'(V_IDLE));
        tick();
        chk({tag, "_n2"}, 32'(obs()), 32'(mid));
        for (int i = 1; i < lat; i++) begin
            tick();
            chk({tag, "_wait"}, 32'(obs()), 32'(mid));
        end
        tick();
        chk({tag, "_ack"}, 32'(obs()), 32'(fin));
        tick();
        chk({tag, "_hold"}, 32'(obs()), 32'(fin));
        end_cycle(tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        sysrst   = 1'b1;
        bif.as_n = 1'b0;
        bif.bg_n = 1'b1;
        set_bus(24'h000400, 3'b110, 1'b1, 1'b0, 1'b0);

        // Reset held with AS low
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset", 32'(obs()), 32'(V_IDLE));
        end
        sysrst = 1'b0;
        tick();
        chk("post_rst_e1", 32'(obs()), 32'(V_IDLE));
        tick();
        chk("post_rst_e2", 32'(obs()), 32'(V_IDLE));
        tick();
        chk("post_rst_e3", 32'(obs()), 32'(V_ROM_MID));
        end_cycle("post_rst");

        // ROM read
        set_bus(24'h000400, 3'b110, 1'b1, 1'b0, 1'b0);
        do_cycle("rom_rd", 5, V_ROM_MID, V_ROM_ACK);

        // RAM2 write, lower byte, five back-to-back cycles
        set_bus(24'h2001FE, 3'b101, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            do_cycle("ram2_wr", 3, V_RAM2W_MID, V_RAM2W_ACK);
        end

        // RAM1 read and RAM1 write with both data strobes idle
        set_bus(24'h1ABCDE, 3'b101, 1'b1, 1'b0, 1'b0);
        do_cycle("ram1_rd", 3, V_RAM1R_MID, V_RAM1R_ACK);
        set_bus(24'h100000, 3'b101, 1'b0, 1'b1, 1'b1);
        do_cycle("ram1_nostb", 3, V_RAM1N_MID, V_RAM1N_ACK);

        // Unmapped access times out into BERR
        set_bus(24'hF00000, 3'b101, 1'b1, 1'b0, 1'b0);
        do_cycle("unmapped", 200, V_UNM_MID, V_UNM_BERR);

        // Interrupt acknowledge wins over an unmapped address
        set_bus(24'hFFFFF1, 3'b111, 1'b1, 1'b0, 1'b0);
        bif.as_n = 1'b0;
        tick();
        tick();
        chk("iack_n1", 32'(obs()), 32'(V_IDLE));
        tick();
        chk("iack_n2", 32'(obs()), 32'(V_IACK));
        tick();
        chk("iack_hold1", 32'(obs()), 32'(V_IACK));
        tick();
        chk("iack_hold2", 32'(obs()), 32'(V_IACK));
        end_cycle("iack");

        // ROM cycle aborted before its acknowledge
        set_bus(24'h000400, 3'b110, 1'b1, 1'b0, 1'b0);
        bif.as_n = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_n2", 32'(obs()), 32'(V_ROM_MID));
        bif.as_n = 1'b1;
        tick();
        chk("abort_n3", 32'(obs()), 32'(V_ROM_MID));
        tick();
        chk("abort_n4", 32'(obs()), 32'(V_ROM_MID));
        tick();
        chk("abort_n5", 32'(obs()), 32'(V_IDLE));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_quiet", 32'(obs()), 32'(V_IDLE));
        end

        // Bus granted away: AS is ignored
        bif.bg_n = 1'b0;
        bif.as_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bus_grant", 32'(obs()), 32'(V_IDLE));
        end
        bif.bg_n = 1'b1;
        tick();
        chk("bg_release", 32'(obs()), 32'(V_ROM_MID));
        end_cycle("bg");

        // Reset in the middle of a cycle
        bif.as_n = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst_n2", 32'(obs()), 32'(V_ROM_MID));
        sysrst = 1'b1;
        tick();
        chk("midrst", 32'(obs()), 32'(V_IDLE));
        bif.as_n = 1'b1;
        sysrst   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_after", 32'(obs()), 32'(V_IDLE));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
